// File: rtl/memory_pkg.sv
// Shared types and constants for the memory game board.
package memory_pkg;

    localparam int N_PAIRS = 8;
    localparam int N_CARDS = 2 * N_PAIRS;
    localparam int IDX_W   = 4;
    localparam int VAL_W   = IDX_W - 1;
    localparam int CNT_W   = $clog2(N_CARDS + 1);

    // Per-card state as seen by the renderer and the game FSM.
    typedef enum logic [1:0] {
        HIDDEN  = 2'd0,
        SHOWN   = 2'd1,
        REMOVED = 2'd2
    } card_state_t;

    // Board operation latched when a request is accepted.
    typedef enum logic [1:0] {
        OP_FLIP   = 2'd0,
        OP_UNFLIP = 2'd1,
        OP_REMOVE = 2'd2
    } board_op_t;

    // Animation sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ANIM = 2'd1,
        ST_DONE = 2'd2
    } anim_state_t;

    // Face value of a card: dropping the low bit of (idx ^ seed) pairs
    // cards 2k and 2k+1 of the scrambled order onto the same value.
    function automatic logic [VAL_W-1:0] card_value(
        input logic [IDX_W-1:0] idx,
        input logic [IDX_W-1:0] key
    );
        logic [IDX_W-1:0] mix;
        mix = idx ^ key;
        return mix[IDX_W-1:1];
    endfunction

endpackage

// File: rtl/board_anim_timer.sv
// Loadable down-counter that times one card animation.
module board_anim_timer #(
    parameter int unsigned ANIM_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic zero
);

    localparam int unsigned CNT_W = (ANIM_CYCLES > 0) ? $clog2(ANIM_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ANIM_CYCLES);

    logic [CNT_W-1:0] count;

    // Count down from the load value and park at zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_board_core.sv
// Board state, shuffle layout and animation sequencing for the memory game.
module memory_board_core #(
    parameter int unsigned N_CARDS     = 16,
    parameter int unsigned ANIM_CYCLES = 12_500_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_game,
    input  logic [3:0]             seed,
    input  logic                   req_flip,
    input  logic                   req_unflip,
    input  logic                   req_remove_pair,
    input  logic [3:0]             act_idx,
    output logic                   flip_ack,
    output logic                   unflip_ack,
    output logic                   remove_ack,
    input  logic [3:0]             sel_idx,
    output logic                   can_flip_sel,
    input  logic [3:0]             q_idx_a,
    input  logic [3:0]             q_idx_b,
    output logic [2:0]             q_val_a,
    output logic [2:0]             q_val_b,
    output logic [2*N_CARDS-1:0]   card_state_flat,
    output logic [3*N_CARDS-1:0]   card_val_flat,
    output logic                   anim_active,
    output logic [3:0]             anim_idx,
    output logic                   all_pairs_done,
    output logic [4:0]             removed_cnt
);

    import memory_pkg::*;

    anim_state_t      state_q;
    anim_state_t      state_d;
    board_op_t        op_q;
    board_op_t        req_op;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] seed_q;
    card_state_t      cards [N_CARDS];
    card_state_t      target;
    logic [CNT_W-1:0] removed_q;
    logic [CNT_W-1:0] shown_cnt;
    logic             all_done_q;
    logic             flip_ack_q;
    logic             unflip_ack_q;
    logic             remove_ack_q;
    logic             req_any;
    logic             accept;
    logic             commit;
    logic             op_legal;
    logic             timer_zero;

    assign req_any = req_flip | req_unflip | req_remove_pair;

    // A request is taken only from IDLE; new_game wins over a coincident request.
    assign accept = (state_q == ST_IDLE) && req_any && !new_game;

    // Animation delay has elapsed: the op takes effect and is acked next cycle.
    assign commit = (state_q == ST_ANIM) && timer_zero;

    board_anim_timer #(
        .ANIM_CYCLES (ANIM_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .clear (new_game),
        .zero  (timer_zero)
    );

    // Shuffle key register: cleared on reset, reloaded on every new game.
    always_ff @(posedge clk) begin
        if (reset) begin
            seed_q <= '0;
        end else if (new_game) begin
            seed_q <= seed;
        end
    end

    // FSM state register; new_game aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_any)    state_d = ST_ANIM;
            ST_ANIM: if (timer_zero) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: animation status towards the renderer.
    always_comb begin
        anim_active = (state_q == ST_ANIM);
        anim_idx    = anim_active ? idx_q : '0;
    end

    // Request arbitration: remove beats unflip beats flip.
    always_comb begin
        req_op = OP_FLIP;
        if (req_remove_pair) begin
            req_op = OP_REMOVE;
        end else if (req_unflip) begin
            req_op = OP_UNFLIP;
        end
    end

    // Latch the accepted operation and its target card.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            op_q  <= OP_FLIP;
            idx_q <= '0;
        end else if (accept) begin
            op_q  <= req_op;
            idx_q <= act_idx;
        end
    end

    // Number of face-up cards; the flip rule keeps this at 2 or below.
    always_comb begin
        shown_cnt = '0;
        for (int i = 0; i < int'(N_CARDS); i++) begin
            if (cards[i] == SHOWN) begin
                shown_cnt = shown_cnt + CNT_W'(1);
            end
        end
    end

    // Legality of the latched op against the current board.
    always_comb begin
        target   = cards[idx_q];
        op_legal = 1'b0;
        unique case (op_q)
            OP_FLIP:   op_legal = (target == HIDDEN) && (shown_cnt < CNT_W'(2));
            OP_UNFLIP: op_legal = (target == SHOWN);
            OP_REMOVE: op_legal = (target == SHOWN);
            default:   op_legal = 1'b0;
        endcase
    end

    // Card states and removal count; illegal ops leave the board untouched.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            // NOTE: the card array is small control state read by the
            // renderer straight after reset, so every entry is cleared.
            for (int i = 0; i < int'(N_CARDS); i++) begin
                cards[i] <= HIDDEN;
            end
            removed_q  <= '0;
            all_done_q <= 1'b0;
        end else if (commit && op_legal) begin
            unique case (op_q)
                OP_FLIP:   cards[idx_q] <= SHOWN;
                OP_UNFLIP: cards[idx_q] <= HIDDEN;
                OP_REMOVE: begin
                    cards[idx_q] <= REMOVED;
                    removed_q    <= removed_q + CNT_W'(1);
                    all_done_q   <= (removed_q == CNT_W'(N_CARDS - 1));
                end
                default: ;
            endcase
        end
    end

    // Registered completion pulses, one per op type, legal or not.
    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            flip_ack_q   <= 1'b0;
            unflip_ack_q <= 1'b0;
            remove_ack_q <= 1'b0;
        end else begin
            flip_ack_q   <= commit && (op_q == OP_FLIP);
            unflip_ack_q <= commit && (op_q == OP_UNFLIP);
            remove_ack_q <= commit && (op_q == OP_REMOVE);
        end
    end

    // Flattened board image for the renderer.
    always_comb begin
        card_state_flat = '0;
        card_val_flat   = '0;
        for (int i = 0; i < int'(N_CARDS); i++) begin
            card_state_flat[2*i +: 2] = cards[i];
            card_val_flat[3*i +: 3]   = card_value(IDX_W'(i), seed_q);
        end
    end

    assign can_flip_sel   = (cards[sel_idx] == HIDDEN) && (shown_cnt < CNT_W'(2));
    assign q_val_a        = card_value(q_idx_a, seed_q);
    assign q_val_b        = card_value(q_idx_b, seed_q);
    assign flip_ack       = flip_ack_q;
    assign unflip_ack     = unflip_ack_q;
    assign remove_ack     = remove_ack_q;
    assign removed_cnt    = removed_q;
    assign all_pairs_done = all_done_q;

endmodule

// File: doc/memory_board_core.md
Name: memory_board_core

Overview:
- Owns the 16-card board of the two-player memory game: per-card state, the shuffled face values, and the animation delay for flips, unflips and removals.
- Serves the game FSM through request/ack handshakes, and tells it whether the card under the cursor can be flipped.
- Supplies face values to the pair checker and the full board image to the VGA renderer.
- Sits directly downstream of the game FSM.

Parameters:
- N_CARDS, 16, number of cards; must be 16 (4-bit indices, 8 pairs).
- ANIM_CYCLES, 12_500_000, clock cycles an animation lasts before its ack; 0 is legal.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- new_game  in  1  pulse; clears the board and latches a new shuffle from seed
- seed  in  4  shuffle key, sampled on new_game
- req_flip  in  1  request HIDDEN->SHOWN on act_idx
- req_unflip  in  1  request SHOWN->HIDDEN on act_idx
- req_remove_pair  in  1  request SHOWN->REMOVED on act_idx
- act_idx  in  4  target card of the request, sampled with the request
- flip_ack  out  1  one-cycle completion pulse for a flip
- unflip_ack  out  1  one-cycle completion pulse for an unflip
- remove_ack  out  1  one-cycle completion pulse for a removal
- sel_idx  in  4  cursor index
- can_flip_sel  out  1  card at sel_idx is HIDDEN and fewer than 2 cards are SHOWN
- q_idx_a  in  4  pair-check query index A
- q_idx_b  in  4  pair-check query index B
- q_val_a  out  3  face value of card q_idx_a (combinational)
- q_val_b  out  3  face value of card q_idx_b (combinational)
- card_state_flat  out  32  2 bits per card; card i at [2i+1:2i]
- card_val_flat  out  48  3 bits per card; card i at [3i+2:3i]
- anim_active  out  1  high while an animation is in progress
- anim_idx  out  4  card being animated; valid while anim_active
- all_pairs_done  out  1  high when all 16 cards are REMOVED
- removed_cnt  out  5  number of REMOVED cards, 0..16

Behaviour:
- Card state encoding: HIDDEN=0, SHOWN=1, REMOVED=2; value 3 is never produced.
- Layout: value[i] = (i XOR seed_q)[3:1], so every value 0..7 appears exactly twice.
- seed_q is the registered copy of seed.
- Reset, and new_game at any time (including mid-animation):
  - all cards HIDDEN; removed_cnt=0.
  - seed_q=0 on reset; seed_q=seed on new_game.
  - FSM returns to IDLE; anim counter=0; acks 0; anim_active=0; anim_idx=0.
  - An aborted operation is never acked and changes no card.
- FSM states: IDLE, ANIM, DONE.
- IDLE:
  - On any request, latch op and act_idx, load the counter with ANIM_CYCLES, go to ANIM.
  - Priority when requests coincide: remove > unflip > flip. The lower-priority requests are dropped.
- ANIM:
  - anim_active=1; anim_idx = latched index.
  - Counter decrements each cycle; at 0 go to DONE.
  - With ANIM_CYCLES=0, ANIM lasts exactly 1 cycle.
- DONE (1 cycle):
  - Apply the state change if legal.
  - Pulse the ack matching the op, even when the op was illegal.
  - Return to IDLE.
- Latency: request at cycle t -> state change and ack at cycle t+ANIM_CYCLES+2. The ack is registered.
- Legality:
  - flip needs HIDDEN and shown count < 2.
  - unflip needs SHOWN.
  - remove needs SHOWN.
  - An illegal op still runs the full animation delay and acks, with no state change.
- removed_cnt increments by 1 on each legal remove. all_pairs_done = (removed_cnt == 16), registered with removed_cnt.
- Requests arriving while not in IDLE are ignored; they are not queued.
- can_flip_sel, q_val_a, q_val_b: combinational from registered state; no dependence on FSM state.
- Shown count: combinational popcount of SHOWN cards, 0..2.

Decomposition:
- Package memory_pkg:
  - card_state_t enum (HIDDEN, SHOWN, REMOVED).
  - board_op_t enum (OP_FLIP, OP_UNFLIP, OP_REMOVE).
  - Constants N_CARDS=16, N_PAIRS=8, IDX_W=4, VAL_W=3.
- One sub-module: board_anim_timer.
  - Loadable down-counter parameterised by ANIM_CYCLES.
  - Inputs load/clear; output zero flag.

Test Plan (ANIM_CYCLES=4):
- Reset, then new_game with seed=4'hA -> card_val_flat shows value[0]=5, value[10]=0, each value 0..7 exactly twice; all states HIDDEN; can_flip_sel=1 for every sel_idx.
- req_flip on idx 3 at cycle t -> anim_active cycles t+1..t+5, flip_ack at t+6 only, card 3 SHOWN at t+6; can_flip_sel(sel_idx=3)=0.
- Flip 2 and 9, then req_flip on 5 -> flip_ack at t+6, card 5 stays HIDDEN; can_flip_sel=0 for all sel_idx while 2 cards are SHOWN.
- Same-cycle req_flip and req_remove_pair on a SHOWN card 7 -> only remove_ack pulses; card 7 REMOVED; removed_cnt=1.
- new_game issued mid-ANIM of an unflip -> no unflip_ack ever; board all HIDDEN next cycle; FSM in IDLE.
- Scripted removal of all 16 cards -> removed_cnt=16; all_pairs_done rises in the same cycle as the final remove_ack.
